// File: rtl/hazard_pkg.sv
// Shared types for the RV32 hazard controller.
//   fwd_sel_t  : operand-forwarding select driven into the E-stage operand muxes
//   hz_state_t : data-memory wait FSM state
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT,
    FAULT
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Per-operand forwarding select for the E stage.
//   rs          : source register of the operand in E
//   rd_m/_w     : destination registers in M / W
//   reg_write_* : M / W write the register file
//   sel         : FWD_MEM when M matches, else FWD_WB when W matches, else FWD_RF
// x0 is never forwarded; M has priority because it holds the younger result.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output fwd_sel_t          sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline.
//   Inputs : D/E source registers, E/M/W destinations and write enables,
//            load_e, pc_src_e, data-memory request/ready handshake.
//   Outputs: forward_a_e/forward_b_e operand selects, stall_f/d/e/m and
//            flush_d/e/w pipeline-register controls, sticky mem_fault,
//            saturating stall_cnt/flush_cnt performance counters.
// rst is asynchronous and active low.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              load_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  input  logic              pc_src_e,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              mem_fault,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);

  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  hz_state_t         state_q, state_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lwstall;
  logic memstall;
  logic flush_taken;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .rs          (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .sel         (fwd_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .rs          (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .sel         (fwd_b)
  );

  assign lwstall  = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  assign memstall = dmem_req_m && !dmem_ready;

  // Wait FSM and counter next-state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (memstall) begin
          wait_cnt_d = WCW'(1);
          state_d    = (MEM_TIMEOUT <= 1) ? FAULT : WAIT;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          wait_cnt_d = '0;
          state_d    = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
          if (wait_cnt_d == TIMEOUT_V) begin
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Pipeline controls are combinational so a stall takes effect in the same
  // cycle as the cause; outputs are also held at their reset values while
  // rst is asserted, since memstall/lwstall would otherwise leak through.
  always_comb begin
    forward_a_e = fwd_a;
    forward_b_e = fwd_b;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    flush_taken = 1'b0;
    if (!rst) begin
      forward_a_e = FWD_RF;
      forward_b_e = FWD_RF;
    end else if ((state_q == FAULT) || memstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      // Wrong-path D instruction: any concurrent load-use stall is moot.
      flush_d     = 1'b1;
      flush_e     = 1'b1;
      flush_taken = 1'b1;
    end else if (lwstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
    if (flush_taken && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_fault = (state_q == FAULT);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
